fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC register, issues requests to instruction memory over a single-outstanding req/rvalid handshake, and drives the IF/ID pipeline register consumed by decode. It sits directly upstream of decode. It obeys `stall_f`, `stall_d` and `flush_d` from the hazard unit, and takes the execute-stage redirect (`pcsrc_e`, `pc_target_e`). It inserts bubbles whenever memory has not delivered.

## Interface
- `XLEN`, 32: address/instruction width.
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset.
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall_f` in 1: hazard unit; hold PC.
- `stall_d` in 1: hazard unit; hold IF/ID.
- `flush_d` in 1: hazard unit; load bubble into IF/ID.
- `pcsrc_e` in 1: execute redirect taken.
- `pc_target_e` in XLEN: redirect target; bits [1:0] ignored, forced to 0.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out XLEN: fetch address (= `pc_f`).
- `imem_ready` in 1: request accepted when `imem_req && imem_ready`.
- `imem_rvalid` in 1: response valid; earliest one cycle after acceptance.
- `imem_rdata` in XLEN: response instruction.
- `instr_d` out XLEN: IF/ID instruction.
- `pc_d` out XLEN: IF/ID PC.
- `pc_plus4_d` out XLEN: IF/ID PC+4.
- `valid_d` out 1: IF/ID holds a real instruction.

## Operation
- FSM states:
  - IDLE: `imem_req`=1, `imem_addr`=`pc_f`; on accept → WAIT.
  - WAIT: one request outstanding.
  - HELD: response buffered because decode is stalled.
- Only one request may be outstanding; `imem_req`=0 in WAIT and HELD.
- `squash` flag marks the outstanding request as wrong-path.
- Response available (`avail`): WAIT && `imem_rvalid` && !`squash`, or HELD.
- `deliver` = `avail` && !`stall_d` && !`stall_f` && !`flush_d` && !`pcsrc_e`.
- IF/ID update, first match wins:
  - `flush_d` → bubble.
  - `stall_d` → hold.
  - `deliver` → load {rdata or buffer, `pc_f`, `pc_f`+4, valid=1}.
  - otherwise → bubble.
- Bubble is `instr_d`=NOP 32'h0000_0013, `valid_d`=0; `pc_d` and `pc_plus4_d` hold their previous values.
- PC update, first match wins:
  - `pcsrc_e` → `pc_target_e` with [1:0]=0.
  - `deliver` → `pc_f`+4, modulo 2^XLEN (wraps 32'hFFFF_FFFC → 0).
  - otherwise hold.
- WAIT transitions:
  - `imem_rvalid` && `squash` → drop response, clear `squash`, go to IDLE.
  - `imem_rvalid` && `pcsrc_e` → drop response, go to IDLE with no squash.
  - `imem_rvalid` && `deliver` → IDLE.
  - `imem_rvalid`, no deliver, no redirect → capture `imem_rdata` into the hold buffer, go to HELD.
  - No `imem_rvalid` && `pcsrc_e` → set `squash`, stay in WAIT.
- HELD transitions: `pcsrc_e` → discard buffer, go to IDLE; `deliver` → IDLE; otherwise stay.
- IDLE with accept and `pcsrc_e` in the same cycle → WAIT with `squash`=1, because the request carried the old PC.
- `imem_rvalid` in IDLE or HELD (protocol violation) is ignored.

## Timing
- Reset (async, `rst_n`=0) forces, immediately and while held:
  - state IDLE, `squash`=0, `pc_f`=`RESET_PC`;
  - `instr_d`=NOP, `valid_d`=0, `pc_d`=0, `pc_plus4_d`=0;
  - `imem_req`=1 once `rst_n` is released.
- Reset mid-request abandons it; any late response lands in IDLE and is ignored.
- Latency:
  - accept in cycle N, `imem_rvalid` in N+k (k≥1), `valid_d`=1 from edge N+k.
  - Zero-wait memory (k=1, ready=1) gives one instruction per 2 cycles.
- Redirect at edge E:
  - `pc_f`=target at E+0.
  - New request issues in cycle E+1 if IDLE; otherwise after the squashed response drains.
- All outputs are registered except `imem_req` and `imem_addr`, which are state/`pc_f` decodes with no input-to-output combinational path.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_state_t` enum {IDLE, WAIT, HELD};
  - NOP constant 32'h0000_0013;
  - default `RESET_PC`.
- Sub-module `if_id_reg` holds the IF/ID register with flush > stall > load > bubble priority. It is reusable for other stage registers.

## Test plan
- Reset release, ready=1, k=1: `imem_addr` 0 then 4 then 8; `instr_d` sequence matches memory; `valid_d` toggles 0/1.
- Response arrives with `stall_d`=`stall_f`=1 for 3 cycles: state HELD, `instr_d` unchanged; on release the buffered instruction loads and `pc_d`=captured PC.
- `pcsrc_e`=1 with target 32'h0000_0103 while in WAIT, response 2 cycles later: response dropped, `valid_d`=0, next `imem_addr`=32'h0000_0100.
- `pcsrc_e` and `imem_rvalid` in the same cycle: response dropped, no squash, `imem_req` the next cycle at the target.
- `pc_f`=32'hFFFF_FFFC delivers: next `imem_addr`=0, `pc_plus4_d`=0.
- `rst_n` low for 1 cycle mid-WAIT, then a late `imem_rvalid`: ignored, fetch restarts at `RESET_PC`, `valid_d`=0 throughout reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its
// pipeline-register helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// Generic stage register: flush > stall > load > bubble. A bubble clears
// valid and injects a NOP but leaves the PC fields untouched.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BUBBLE_INSTR = XLEN'(NOP)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] instr_next,
  input  logic [XLEN-1:0] pc_next,
  input  logic [XLEN-1:0] pc_plus4_next,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= BUBBLE_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr <= BUBBLE_INSTR;
      valid <= 1'b0;
    end else if (stall) begin
      instr <= instr;
      valid <= valid;
    end else if (load) begin
      instr    <= instr_next;
      pc       <= pc_next;
      pc_plus4 <= pc_plus4_next;
      valid    <= 1'b1;
    end else begin
      instr <= BUBBLE_INSTR;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, single-outstanding imem
// handshake with wrong-path squash, and the IF/ID register feeding decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pcsrc_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  fetch_state_t    state_q, state_n;
  logic            squash_q, squash_n;
  logic            capture;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] hold_buf;
  logic [XLEN-1:0] fetched_instr;
  logic [XLEN-1:0] redirect_pc;
  logic            avail;
  logic            deliver;

  assign imem_req   = (state_q == IDLE);
  assign imem_addr  = pc_f;
  assign pc_plus4_f = pc_f + XLEN'(4);
  assign redirect_pc = pc_target_e & ~XLEN'(3);

  assign avail   = ((state_q == WAIT) && imem_rvalid && !squash_q) || (state_q == HELD);
  assign deliver = avail && !stall_d && !stall_f && !flush_d && !pcsrc_e;
  assign fetched_instr = (state_q == HELD) ? hold_buf : imem_rdata;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n  = state_q;
    squash_n = squash_q;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (imem_ready) begin
          state_n  = WAIT;
          // A redirect in the accept cycle means the request carried the old PC.
          squash_n = pcsrc_e;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (squash_q) begin
            state_n  = IDLE;
            squash_n = 1'b0;
          end else if (pcsrc_e || deliver) begin
            state_n = IDLE;
          end else begin
            state_n = HELD;
            capture = 1'b1;
          end
        end else if (pcsrc_e) begin
          squash_n = 1'b1;
        end
      end
      HELD: begin
        if (pcsrc_e || deliver) state_n = IDLE;
      end
      default: begin
        state_n  = IDLE;
        squash_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      squash_q <= 1'b0;
      pc_f     <= RESET_PC;
    end else begin
      state_q  <= state_n;
      squash_q <= squash_n;
      if (pcsrc_e)      pc_f <= redirect_pc;
      else if (deliver) pc_f <= pc_plus4_f;
    end
  end

  // NOTE: the hold buffer is datapath only and is never read unless HELD was
  // entered through a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) hold_buf <= imem_rdata;
  end

  if_id_reg #(
    .XLEN         (XLEN),
    .BUBBLE_INSTR (XLEN'(NOP))
  ) u_if_id (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush_d),
    .stall         (stall_d),
    .load          (deliver),
    .instr_next    (fetched_instr),
    .pc_next       (pc_f),
    .pc_plus4_next (pc_plus4_f),
    .instr         (instr_d),
    .pc            (pc_d),
    .pc_plus4      (pc_plus4_d),
    .valid         (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID contents
// into a scoreboard that a negedge monitor pops on each new valid_d.
module tb_fetch_stage;
  import fetch_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d, pcsrc_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic hold_prev = 1'b0;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pcsrc_e     (pcsrc_e),
    .pc_target_e (pc_target_e),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd17) ^ 32'h5A5A_0093;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one fetch from IDLE with response latency k and queues its result.
  task automatic fetch_one(input logic [31:0] addr, input int k);
    exp_t e;
    imem_ready = 1'b1;
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, addr);
    e.instr = mem_word(addr);
    e.pc    = addr;
    e.pc4   = addr + 32'd4;
    sb.push_back(e);
    tick();
    check("fetch_wait_bubble", 32'(valid_d), 32'd0);
    repeat (k - 1) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(addr);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAD0_BAD0;
    check("fetch_valid", 32'(valid_d), 32'd1);
  endtask

  // Monitor: one pop per freshly loaded instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_d && !hold_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got instr %h pc %h, expected none", instr_d, pc_d);
        end else begin
          e = sb.pop_front();
          check("sb_instr", instr_d, e.instr);
          check("sb_pc", pc_d, e.pc);
          check("sb_pc4", pc_plus4_d, e.pc4);
        end
      end
      hold_prev = stall_d;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pcsrc_e = 1'b0; pc_target_e = '0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(valid_d), 32'd0);
    check("rst_instr", instr_d, NOP);
    check("rst_pc_d", pc_d, 32'd0);
    check("rst_pc4_d", pc_plus4_d, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait streaming
    fetch_one(32'h0, 1);
    fetch_one(32'h4, 1);
    fetch_one(32'h8, 1);

    // Response arrives while decode and fetch are stalled
    imem_ready = 1'b1;
    check("stall_addr", imem_addr, 32'hC);
    tick();
    stall_d = 1'b1; stall_f = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'hC);
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    repeat (2) begin
      check("held_req", 32'(imem_req), 32'd0);
      check("held_instr", instr_d, NOP);
      tick();
    end
    check("held_valid", 32'(valid_d), 32'd0);
    e.instr = mem_word(32'hC); e.pc = 32'hC; e.pc4 = 32'h10;
    sb.push_back(e);
    stall_d = 1'b0; stall_f = 1'b0;
    tick();
    check("held_release_pc_d", pc_d, 32'hC);
    check("held_next_addr", imem_addr, 32'h10);

    // Redirect while WAIT, late response squashed
    check("redir_addr0", imem_addr, 32'h10);
    tick();
    pcsrc_e = 1'b1; pc_target_e = 32'h0000_0103;
    tick();
    pcsrc_e = 1'b0; pc_target_e = '0;
    check("redir_wait_req", 32'(imem_req), 32'd0);
    check("redir_pc", imem_addr, 32'h100);
    tick();
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'h10);
    tick();
    imem_rvalid = 1'b0;
    check("redir_drop_valid", 32'(valid_d), 32'd0);
    check("redir_req", 32'(imem_req), 32'd1);
    fetch_one(32'h100, 2);

    // Redirect coincident with response
    check("coinc_addr0", imem_addr, 32'h104);
    tick();
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'h104);
    pcsrc_e = 1'b1; pc_target_e = 32'h200;
    tick();
    imem_rvalid = 1'b0; pcsrc_e = 1'b0; pc_target_e = '0;
    check("coinc_valid", 32'(valid_d), 32'd0);
    check("coinc_req", 32'(imem_req), 32'd1);
    check("coinc_addr", imem_addr, 32'h200);
    fetch_one(32'h200, 1);

    // PC wrap at the top of the address space
    imem_ready = 1'b0;
    pcsrc_e = 1'b1; pc_target_e = 32'hFFFF_FFFF;
    tick();
    pcsrc_e = 1'b0; pc_target_e = '0;
    check("wrap_target_align", imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 1);
    check("wrap_next_addr", imem_addr, 32'h0);
    check("wrap_pc4_d", pc_plus4_d, 32'h0);

    // Redirect in the accept cycle squashes the old-PC request
    imem_ready = 1'b1;
    pcsrc_e = 1'b1; pc_target_e = 32'h300;
    tick();
    pcsrc_e = 1'b0; pc_target_e = '0;
    check("acc_redir_req", 32'(imem_req), 32'd0);
    check("acc_redir_pc", imem_addr, 32'h300);
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
    tick();
    imem_rvalid = 1'b0;
    check("acc_redir_valid", 32'(valid_d), 32'd0);
    check("acc_redir_req2", 32'(imem_req), 32'd1);
    check("acc_redir_addr", imem_addr, 32'h300);

    // Flush on the response cycle buffers the instruction
    tick();
    flush_d = 1'b1; imem_rvalid = 1'b1; imem_rdata = mem_word(32'h300);
    tick();
    flush_d = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    check("flush_valid", 32'(valid_d), 32'd0);
    check("flush_held_req", 32'(imem_req), 32'd0);
    e.instr = mem_word(32'h300); e.pc = 32'h300; e.pc4 = 32'h304;
    sb.push_back(e);
    tick();
    check("flush_next_addr", imem_addr, 32'h304);

    // Reset mid-WAIT, then a late response
    tick();
    rst_n = 1'b0;
    #1;
    check("rst2_valid", 32'(valid_d), 32'd0);
    check("rst2_instr", instr_d, NOP);
    check("rst2_pc_d", pc_d, 32'd0);
    check("rst2_addr", imem_addr, 32'd0);
    @(posedge clk);
    #1;
    check("rst2_valid_held", 32'(valid_d), 32'd0);
    imem_ready = 1'b0;
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("late_valid", 32'(valid_d), 32'd0);
    check("late_req", 32'(imem_req), 32'd1);
    check("late_addr", imem_addr, 32'd0);
    fetch_one(32'h0, 1);

    imem_ready = 1'b0;
    repeat (2) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
